// File: rtl/snek_pkg.sv
// snek_pkg
//   Shared definitions for the snake game controller: FSM state codes,
//   direction codes with their 180-degree reverse, grid dimensions,
//   the food LFSR feedback taps and the food position after reset.
//   No ports (package).
package snek_pkg;

    typedef enum logic [1:0] {
        ST_SPLASH = 2'd0,
        ST_PLAY   = 2'd1,
        ST_OVER   = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        DIR_LEFT  = 3'd0,
        DIR_RIGHT = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_UP    = 3'd3,
        DIR_HOLD  = 3'd4
    } dir_t;

    localparam int GRID_W = 32;
    localparam int GRID_H = 24;

    // Galois form of x^16 + x^14 + x^13 + x^11 for a right-shifting register
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam logic [5:0] FOOD_RESET_H = 6'd20;
    localparam logic [5:0] FOOD_RESET_V = 6'd11;

    // HOLD has no opposite, so it maps to itself and never blocks a press
    function automatic dir_t reverse_dir(input dir_t d);
        dir_t r;
        case (d)
            DIR_LEFT:  r = DIR_RIGHT;
            DIR_RIGHT: r = DIR_LEFT;
            DIR_DOWN:  r = DIR_UP;
            DIR_UP:    r = DIR_DOWN;
            default:   r = DIR_HOLD;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/snek_food_lfsr.sv
// snek_food_lfsr
//   Food placement for the snake game. A 16-bit LFSR free-runs every cycle;
//   on a request the next candidate cell is taken from lfsr[4:0] (column) and
//   lfsr[9:5] (row). A candidate is accepted only if it lies on the grid and
//   is not the head cell; otherwise a new candidate is tried next cycle. The
//   previous food cell is held until a candidate is accepted.
// Ports
//   i_clk      in   1  clock
//   i_rst      in   1  synchronous active-high reset
//   i_req      in   1  one-cycle relocation request
//   i_head_h   in   6  snake head column
//   i_head_v   in   6  snake head row
//   o_food_h   out  6  food column
//   o_food_v   out  6  food row
//   o_valid    out  1  low while a relocation is still searching
module snek_food_lfsr
    import snek_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req,
    input  logic [5:0] i_head_h,
    input  logic [5:0] i_head_v,
    output logic [5:0] o_food_h,
    output logic [5:0] o_food_v,
    output logic       o_valid
);

    logic [15:0] r_lfsr;
    logic [5:0]  r_food_h;
    logic [5:0]  r_food_v;
    logic        r_pend;

    logic [15:0] w_lfsr_next;
    logic [5:0]  w_cand_h;
    logic [5:0]  w_cand_v;
    logic        w_accept;
    logic        w_search;

    assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_TAPS) : (r_lfsr >> 1);

    assign w_cand_h = {1'b0, r_lfsr[4:0]};
    assign w_cand_v = {1'b0, r_lfsr[9:5]};

    assign w_accept = (w_cand_h < 6'(GRID_W)) && (w_cand_v < 6'(GRID_H)) &&
                      !((w_cand_h == i_head_h) && (w_cand_v == i_head_v));

    // The request itself already tries a candidate, so a lucky first draw
    // moves the food on the cycle right after the eat.
    assign w_search = i_req | r_pend;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lfsr   <= LFSR_SEED;
            r_food_h <= FOOD_RESET_H;
            r_food_v <= FOOD_RESET_V;
            r_pend   <= 1'b0;
        end else begin
            r_lfsr <= w_lfsr_next;
            if (w_search) begin
                if (w_accept) begin
                    r_food_h <= w_cand_h;
                    r_food_v <= w_cand_v;
                    r_pend   <= 1'b0;
                end else begin
                    r_pend   <= 1'b1;
                end
            end
        end
    end

    assign o_food_h = r_food_h;
    assign o_food_v = r_food_v;
    assign o_valid  = ~r_pend;

endmodule

// File: rtl/snek_game_ctrl.sv
// snek_game_ctrl
//   Game sequencer for the snake datapath. Runs SPLASH -> PLAY -> OVER,
//   paces movement with a one-cycle run strobe every STEP_FRAMES frames,
//   latches the player direction, detects eating, requests growth and keeps
//   a saturating score. Food placement lives in snek_food_lfsr.
// Optional feature
//   SNEK_SPEEDUP_EN: when defined, the step period shrinks by one frame on
//   every 4th score increment down to MIN_STEP_FRAMES, taking effect at the
//   next step counter wrap. Undefined: the period is fixed at STEP_FRAMES.
// Ports
//   i_frame_clk  in   1  frame-rate clock
//   i_rst        in   1  synchronous active-high reset
//   i_btn_l/r/u/d in  1  direction buttons (level, synchronised)
//   i_btn_start  in   1  start button (level)
//   i_head_h     in   6  snake head column
//   i_head_v     in   6  snake head row
//   i_body_len   in   8  current snake length
//   i_dead       in   1  snake collision flag
//   o_snek_rst   out  1  reset to the snake datapath
//   o_run        out  1  step strobe
//   o_grow_flag  out  1  grow request, only with o_run
//   o_dir        out  3  0 left, 1 right, 2 down, 3 up, 4 hold
//   o_food_h/v   out  6  food cell
//   o_score      out  8  food eaten this game
//   o_state      out  2  0 SPLASH, 1 PLAY, 2 OVER
module snek_game_ctrl
    import snek_pkg::*;
#(
    parameter int          MAXLEN          = 16,
    parameter int          STEP_FRAMES     = 8,
    parameter int          MIN_STEP_FRAMES = 3,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic       i_frame_clk,
    input  logic       i_rst,
    input  logic       i_btn_l,
    input  logic       i_btn_r,
    input  logic       i_btn_u,
    input  logic       i_btn_d,
    input  logic       i_btn_start,
    input  logic [5:0] i_head_h,
    input  logic [5:0] i_head_v,
    input  logic [7:0] i_body_len,
    input  logic       i_dead,
    output logic       o_snek_rst,
    output logic       o_run,
    output logic       o_grow_flag,
    output logic [2:0] o_dir,
    output logic [5:0] o_food_h,
    output logic [5:0] o_food_v,
    output logic [7:0] o_score,
    output logic [1:0] o_state
);

    localparam int CNT_W = $clog2(STEP_FRAMES + 1);
    localparam logic [CNT_W-1:0] PERIOD_INIT = CNT_W'(STEP_FRAMES);

    if (STEP_FRAMES < 2 || MIN_STEP_FRAMES < 1 || MIN_STEP_FRAMES > STEP_FRAMES) begin : g_bad_period
        $error("snek_game_ctrl: step period parameters out of range");
    end

    state_t           r_state;
    state_t           w_state_next;
    dir_t             r_dir;
    dir_t             w_btn_dir;
    logic             w_btn_valid;
    logic             w_dir_load;
    logic             r_btn_start_q;
    logic             w_start_edge;
    logic [CNT_W-1:0] r_step_cnt;
    logic [CNT_W-1:0] w_period;
    logic             w_step_last;
    logic [7:0]       r_score;
    logic             w_score_inc;
    logic             r_grow_pend;
    logic             w_room;
    logic             w_eat;
    logic             w_run;
    logic             w_grow;
    logic             w_snek_rst;
    logic [5:0]       w_food_h;
    logic [5:0]       w_food_v;
    logic             w_food_valid;

`ifdef SNEK_SPEEDUP_EN
    localparam logic [CNT_W-1:0] PERIOD_MIN = CNT_W'(MIN_STEP_FRAMES);
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_period_target;
    logic [1:0]       r_eat_cnt;
    assign w_period = r_period;
`else
    assign w_period = PERIOD_INIT;
`endif

    assign w_start_edge = i_btn_start & ~r_btn_start_q;
    assign w_step_last  = (r_step_cnt == (w_period - CNT_W'(1)));
    assign w_room       = (i_body_len < 8'(MAXLEN));

    // Eating waits for a settled food cell so a stale position under the
    // head cannot be eaten twice while relocation is still searching.
    assign w_eat = (r_state == ST_PLAY) && (i_head_h == w_food_h) &&
                   (i_head_v == w_food_v) && !r_grow_pend && w_food_valid;
    assign w_score_inc = w_eat && (r_score != 8'hFF);

    // Button priority left > right > up > down
    always_comb begin
        w_btn_dir   = DIR_HOLD;
        w_btn_valid = 1'b1;
        if (i_btn_l)      w_btn_dir = DIR_LEFT;
        else if (i_btn_r) w_btn_dir = DIR_RIGHT;
        else if (i_btn_u) w_btn_dir = DIR_UP;
        else if (i_btn_d) w_btn_dir = DIR_DOWN;
        else              w_btn_valid = 1'b0;
    end

    assign w_dir_load = (r_state == ST_PLAY) && w_btn_valid &&
                        (w_btn_dir != reverse_dir(r_dir));

    always_ff @(posedge i_frame_clk) begin
        if (i_rst) r_state <= ST_SPLASH;
        else       r_state <= w_state_next;
    end

    // A dead flag suppresses the strobe on the very cycle it is seen
    always_comb begin
        w_state_next = r_state;
        w_snek_rst   = 1'b0;
        w_run        = 1'b0;
        w_grow       = 1'b0;
        case (r_state)
            ST_SPLASH: begin
                w_snek_rst = 1'b1;
                if (w_start_edge) w_state_next = ST_PLAY;
            end
            ST_PLAY: begin
                w_run  = w_step_last & ~i_dead;
                w_grow = w_step_last & ~i_dead & r_grow_pend & w_room;
                if (i_dead) w_state_next = ST_OVER;
            end
            ST_OVER: begin
                if (w_start_edge) w_state_next = ST_SPLASH;
            end
            default: begin
                w_state_next = ST_SPLASH;
                w_snek_rst   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_frame_clk) begin
        if (i_rst) begin
            r_btn_start_q <= 1'b0;
            r_dir         <= DIR_HOLD;
            r_score       <= 8'd0;
            r_step_cnt    <= '0;
            r_grow_pend   <= 1'b0;
        end else begin
            r_btn_start_q <= i_btn_start;
            if ((r_state == ST_SPLASH) && w_start_edge) begin
                r_dir       <= DIR_HOLD;
                r_score     <= 8'd0;
                r_step_cnt  <= '0;
                r_grow_pend <= 1'b0;
            end else if (r_state == ST_PLAY) begin
                r_step_cnt <= w_step_last ? '0 : r_step_cnt + CNT_W'(1);
                if (w_dir_load) r_dir <= w_btn_dir;
                // A strobe with a full snake still consumes the pending grow
                if (w_eat) begin
                    r_grow_pend <= 1'b1;
                    if (w_score_inc) r_score <= r_score + 8'd1;
                end else if (w_run && r_grow_pend) begin
                    r_grow_pend <= 1'b0;
                end
            end
        end
    end

`ifdef SNEK_SPEEDUP_EN
    // The target shrinks on every 4th point; the live period only follows it
    // at a wrap so a step in progress is never cut short.
    always_ff @(posedge i_frame_clk) begin
        if (i_rst) begin
            r_period        <= PERIOD_INIT;
            r_period_target <= PERIOD_INIT;
            r_eat_cnt       <= 2'd0;
        end else if ((r_state == ST_SPLASH) && w_start_edge) begin
            r_period        <= PERIOD_INIT;
            r_period_target <= PERIOD_INIT;
            r_eat_cnt       <= 2'd0;
        end else if (r_state == ST_PLAY) begin
            if (w_step_last) r_period <= r_period_target;
            if (w_score_inc) begin
                r_eat_cnt <= r_eat_cnt + 2'd1;
                if ((r_eat_cnt == 2'd3) && (r_period_target > PERIOD_MIN))
                    r_period_target <= r_period_target - CNT_W'(1);
            end
        end
    end
`endif

    snek_food_lfsr #(
        .LFSR_SEED (LFSR_SEED)
    ) u_food (
        .i_clk    (i_frame_clk),
        .i_rst    (i_rst),
        .i_req    (w_eat),
        .i_head_h (i_head_h),
        .i_head_v (i_head_v),
        .o_food_h (w_food_h),
        .o_food_v (w_food_v),
        .o_valid  (w_food_valid)
    );

    assign o_snek_rst  = w_snek_rst;
    assign o_run       = w_run;
    assign o_grow_flag = w_grow;
    assign o_dir       = r_dir;
    assign o_food_h    = w_food_h;
    assign o_food_v    = w_food_v;
    assign o_score     = r_score;
    assign o_state     = r_state;

endmodule

// File: tb/tb_snek_game_ctrl.sv
// tb_snek_game_ctrl
//   Directed bench for snek_game_ctrl: reset values, start edge handling,
//   run strobe cadence, direction latch, eating/grow, full-length snake,
//   death, restart, mid-game reset and (with SNEK_SPEEDUP_EN) the speedup.
module tb_snek_game_ctrl;

    localparam int STEP_FRAMES = 8;
    localparam int MAXLEN      = 16;
    // Row 30 is off-grid, so food can never be placed under a parked head
    localparam logic [5:0] PARK_H = 6'd0;
    localparam logic [5:0] PARK_V = 6'd30;

    logic       clk;
    logic       rst;
    logic       btn_l, btn_r, btn_u, btn_d, btn_start;
    logic [5:0] head_h, head_v;
    logic [7:0] body_len;
    logic       dead;
    logic       snek_rst, run, grow_flag;
    logic [2:0] dir;
    logic [5:0] food_h, food_v;
    logic [7:0] score;
    logic [1:0] state;

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_score    = 0;

    snek_game_ctrl #(
        .MAXLEN          (MAXLEN),
        .STEP_FRAMES     (STEP_FRAMES),
        .MIN_STEP_FRAMES (3),
        .LFSR_SEED       (16'hACE1)
    ) dut (
        .i_frame_clk (clk),
        .i_rst       (rst),
        .i_btn_l     (btn_l),
        .i_btn_r     (btn_r),
        .i_btn_u     (btn_u),
        .i_btn_d     (btn_d),
        .i_btn_start (btn_start),
        .i_head_h    (head_h),
        .i_head_v    (head_v),
        .i_body_len  (body_len),
        .i_dead      (dead),
        .o_snek_rst  (snek_rst),
        .o_run       (run),
        .o_grow_flag (grow_flag),
        .o_dir       (dir),
        .o_food_h    (food_h),
        .o_food_v    (food_v),
        .o_score     (score),
        .o_state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++; if (state !== 2'd0) begin tests_failed++; $display("[TB] FAIL reset_state: got %0d want 0", state); end
        tests_run++; if (snek_rst !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_snek_rst: got %b want 1", snek_rst); end
        tests_run++; if (dir !== 3'd4) begin tests_failed++; $display("[TB] FAIL reset_dir: got %0d want 4", dir); end
        tests_run++; if (food_h !== 6'd20 || food_v !== 6'd11) begin tests_failed++; $display("[TB] FAIL reset_food: got (%0d,%0d) want (20,11)", food_h, food_v); end
        tests_run++; if (score !== 8'd0) begin tests_failed++; $display("[TB] FAIL reset_score: got %0d want 0", score); end
        tests_run++; if (run !== 1'b0 || grow_flag !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_run_grow: got run=%b grow=%b want 0/0", run, grow_flag); end
        n = 0;
        repeat (50) begin
            tick();
            if (run !== 1'b0) n++;
        end
        tests_run++; if (n != 0) begin tests_failed++; $display("[TB] FAIL splash_no_run: got %0d pulses want 0", n); end
        tests_run++; if (state !== 2'd0) begin tests_failed++; $display("[TB] FAIL splash_stays: got state %0d want 0", state); end
    endtask

    task automatic test_start();
        int entries;
        logic [1:0] prev;
        logic exp_run;
        entries = 0;
        prev = state;
        btn_start = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (k == 10) btn_start = 1'b0;
            if (prev == 2'd0 && state == 2'd1) entries++;
            prev = state;
            if (k == 1) begin
                tests_run++; if (state !== 2'd1 || snek_rst !== 1'b0) begin tests_failed++; $display("[TB] FAIL play_entry: got state=%0d snek_rst=%b want 1/0", state, snek_rst); end
            end
            exp_run = ((k % STEP_FRAMES) == 0);
            tests_run++; if (run !== exp_run) begin tests_failed++; $display("[TB] FAIL run_cadence cycle %0d: got %b want %b", k, run, exp_run); end
        end
        tests_run++; if (entries != 1) begin tests_failed++; $display("[TB] FAIL start_held_entries: got %0d want 1", entries); end
        tests_run++; if (dir !== 3'd4) begin tests_failed++; $display("[TB] FAIL dir_hold_before_press: got %0d want 4", dir); end
    endtask

    task automatic test_direction();
        btn_r = 1'b1; tick(); btn_r = 1'b0;
        tests_run++; if (dir !== 3'd1) begin tests_failed++; $display("[TB] FAIL dir_right: got %0d want 1", dir); end
        btn_l = 1'b1; tick(); btn_l = 1'b0;
        tests_run++; if (dir !== 3'd1) begin tests_failed++; $display("[TB] FAIL dir_reverse_lr: got %0d want 1", dir); end
        btn_u = 1'b1; tick(); btn_u = 1'b0;
        tests_run++; if (dir !== 3'd3) begin tests_failed++; $display("[TB] FAIL dir_up: got %0d want 3", dir); end
        btn_d = 1'b1; tick(); btn_d = 1'b0;
        tests_run++; if (dir !== 3'd3) begin tests_failed++; $display("[TB] FAIL dir_reverse_ud: got %0d want 3", dir); end
        btn_l = 1'b1; btn_u = 1'b1; tick(); btn_l = 1'b0; btn_u = 1'b0;
        tests_run++; if (dir !== 3'd0) begin tests_failed++; $display("[TB] FAIL dir_priority_lu: got %0d want 0", dir); end
    endtask

    task automatic test_eat();
        int moved, run_seen, bad_grow;
        logic grow_at_run;
        moved = 0; run_seen = 0; bad_grow = 0; grow_at_run = 1'b0;
        tests_run++; if (score !== 8'd0) begin tests_failed++; $display("[TB] FAIL score_before_eat: got %0d want 0", score); end
        head_h = 6'd20; head_v = 6'd11;
        tick();
        head_h = PARK_H; head_v = PARK_V;
        tests_run++; if (score !== 8'd1) begin tests_failed++; $display("[TB] FAIL eat_score: got %0d want 1", score); end
        for (int i = 0; i < 3 * STEP_FRAMES; i++) begin
            tick();
            if (food_h != 6'd20 || food_v != 6'd11) moved = 1;
            if (grow_flag === 1'b1 && run !== 1'b1) bad_grow++;
            if (run === 1'b1 && run_seen == 0) begin
                run_seen = 1;
                grow_at_run = grow_flag;
            end
        end
        tests_run++; if (moved != 1) begin tests_failed++; $display("[TB] FAIL food_moved: got (%0d,%0d) want a new cell", food_h, food_v); end
        tests_run++; if (!(food_v < 6'd24 && food_h < 6'd32)) begin tests_failed++; $display("[TB] FAIL food_on_grid: got (%0d,%0d) want h<32 v<24", food_h, food_v); end
        tests_run++; if (run_seen != 1 || grow_at_run !== 1'b1) begin tests_failed++; $display("[TB] FAIL grow_on_run: got seen=%0d grow=%b want 1/1", run_seen, grow_at_run); end
        tests_run++; if (bad_grow != 0) begin tests_failed++; $display("[TB] FAIL grow_without_run: got %0d cycles want 0", bad_grow); end
    endtask

    task automatic test_max_len();
        int runs;
        logic grow_at_run [2];
        runs = 0;
        grow_at_run[0] = 1'b1; grow_at_run[1] = 1'b1;
        body_len = 8'(MAXLEN);
        head_h = food_h; head_v = food_v;
        tick();
        head_h = PARK_H; head_v = PARK_V;
        tests_run++; if (score !== 8'd2) begin tests_failed++; $display("[TB] FAIL full_eat_score: got %0d want 2", score); end
        for (int i = 0; i < 3 * STEP_FRAMES && runs < 2; i++) begin
            tick();
            if (run === 1'b1) begin
                grow_at_run[runs] = grow_flag;
                runs++;
                body_len = 8'd3;
            end
        end
        tests_run++; if (runs != 2) begin tests_failed++; $display("[TB] FAIL full_runs_seen: got %0d want 2", runs); end
        tests_run++; if (grow_at_run[0] !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_no_grow: got %b want 0", grow_at_run[0]); end
        tests_run++; if (grow_at_run[1] !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_pend_cleared: got %b want 0", grow_at_run[1]); end
    endtask

    task automatic test_death();
        int found, n;
        found = 0;
        for (int i = 0; i < 2 * STEP_FRAMES; i++) begin
            tick();
            if (run === 1'b1) begin found = 1; break; end
        end
        tests_run++; if (found != 1) begin tests_failed++; $display("[TB] FAIL death_find_run: got %0d want 1", found); end
        dead = 1'b1;
        #1;
        tests_run++; if (run !== 1'b0) begin tests_failed++; $display("[TB] FAIL death_coincident_run: got %b want 0", run); end
        tick();
        tests_run++; if (state !== 2'd2 || snek_rst !== 1'b0) begin tests_failed++; $display("[TB] FAIL death_over: got state=%0d snek_rst=%b want 2/0", state, snek_rst); end
        n = 0;
        repeat (20) begin
            tick();
            if (run !== 1'b0) n++;
        end
        tests_run++; if (n != 0) begin tests_failed++; $display("[TB] FAIL over_no_run: got %0d pulses want 0", n); end
    endtask

    task automatic test_restart();
        btn_start = 1'b1;
        tick();
        tests_run++; if (state !== 2'd0 || snek_rst !== 1'b1) begin tests_failed++; $display("[TB] FAIL over_to_splash: got state=%0d snek_rst=%b want 0/1", state, snek_rst); end
        btn_start = 1'b0; dead = 1'b0;
        tick();
        tests_run++; if (state !== 2'd0) begin tests_failed++; $display("[TB] FAIL splash_after_restart: got %0d want 0", state); end
    endtask

    task automatic test_reset_mid_play();
        btn_start = 1'b1; tick(); btn_start = 1'b0;
        tests_run++; if (state !== 2'd1 || score !== 8'd0) begin tests_failed++; $display("[TB] FAIL second_game: got state=%0d score=%0d want 1/0", state, score); end
        btn_u = 1'b1; tick(); btn_u = 1'b0;
        head_h = food_h; head_v = food_v;
        tick();
        head_h = PARK_H; head_v = PARK_V;
        tests_run++; if (dir !== 3'd3 || score !== 8'd1) begin tests_failed++; $display("[TB] FAIL mid_play_setup: got dir=%0d score=%0d want 3/1", dir, score); end
        rst = 1'b1; tick(); rst = 1'b0;
        tests_run++; if (state !== 2'd0 || snek_rst !== 1'b1 || dir !== 3'd4 || score !== 8'd0) begin tests_failed++; $display("[TB] FAIL mid_reset_ctrl: got state=%0d snek_rst=%b dir=%0d score=%0d want 0/1/4/0", state, snek_rst, dir, score); end
        tests_run++; if (food_h !== 6'd20 || food_v !== 6'd11 || run !== 1'b0 || grow_flag !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_reset_food_run: got food=(%0d,%0d) run=%b grow=%b want (20,11)/0/0", food_h, food_v, run, grow_flag); end
        tick();
    endtask

`ifdef SNEK_SPEEDUP_EN
    task automatic eat_once();
        int runs;
        head_h = food_h; head_v = food_v;
        tick();
        head_h = PARK_H; head_v = PARK_V;
        exp_score++;
        tests_run++; if (score !== 8'(exp_score)) begin tests_failed++; $display("[TB] FAIL speed_eat_score: got %0d want %0d", score, exp_score); end
        runs = 0;
        for (int i = 0; i < 4 * STEP_FRAMES && runs < 3; i++) begin
            tick();
            if (run === 1'b1) runs++;
        end
        repeat (10) tick();
    endtask

    task automatic measure_period(input int expected);
        int found, cnt;
        found = 0;
        for (int i = 0; i < 2 * STEP_FRAMES; i++) begin
            tick();
            if (run === 1'b1) begin found = 1; break; end
        end
        cnt = 0;
        if (found == 1) begin
            do begin
                tick();
                cnt++;
            end while (run !== 1'b1 && cnt < 2 * STEP_FRAMES);
        end
        tests_run++; if (cnt != expected) begin tests_failed++; $display("[TB] FAIL speed_period score %0d: got %0d want %0d", exp_score, cnt, expected); end
    endtask

    task automatic test_speedup();
        btn_start = 1'b1; tick(); btn_start = 1'b0;
        tests_run++; if (state !== 2'd1 || score !== 8'd0) begin tests_failed++; $display("[TB] FAIL speed_game_start: got state=%0d score=%0d want 1/0", state, score); end
        exp_score = 0;
        measure_period(STEP_FRAMES);
        for (int g = 1; g <= 6; g++) begin
            repeat (4) eat_once();
            measure_period((STEP_FRAMES - g) > 3 ? (STEP_FRAMES - g) : 3);
        end
    endtask
`endif

    initial begin
        rst = 1'b0; btn_l = 1'b0; btn_r = 1'b0; btn_u = 1'b0; btn_d = 1'b0;
        btn_start = 1'b0; head_h = PARK_H; head_v = PARK_V;
        body_len = 8'd3; dead = 1'b0;
        test_reset();
        test_start();
        test_direction();
        test_eat();
        test_max_len();
        test_death();
        test_restart();
        test_reset_mid_play();
`ifdef SNEK_SPEEDUP_EN
        test_speedup();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
